// File: rtl/uart_code_loader.sv
// uart_code_loader: framed boot loader sitting between the UART receiver and
// the code RAM write port. A frame is SYNC_BYTE, LEN_LO, LEN_HI, LEN payload
// bytes and an XOR checksum. Payload bytes are streamed into the RAM as they
// arrive. core_ready_o is raised only after a whole frame has verified.
//
// Handshake: rx_valid_i is a single-cycle strobe and rx_data_i is sampled in
// that cycle. There is no backpressure, so a byte is consumed on every cycle
// that rx_valid_i is high, including back-to-back cycles.
//
// Optional feature: define BOOT_TIMEOUT_EN to abort a stalled frame once no
// byte has arrived for TIMEOUT_CYCLES clock cycles while busy.
//
// ADDR_WIDTH is expected to be 16 or less, because LEN is a 16-bit field.
module uart_code_loader #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_data_o,
    output logic                  mem_we_o,
    output logic                  core_ready_o,
    output logic                  load_error_o,
    output logic                  busy_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_e;

    // One extra index bit so that a full 2**ADDR_WIDTH byte image can terminate.
    localparam int          IW      = ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    state_e                state_q;
    logic [15:0]           len_q;
    logic [IW-1:0]         idx_q;
    logic [7:0]            chk_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_data_q;
    logic                  mem_we_q;
    logic                  core_ready_q;
    logic                  load_error_q;
    logic                  busy_q;

    logic [15:0]           len_d;
    logic                  len_bad_d;
    logic [IW-1:0]         idx_d;
    logic                  last_d;
    logic                  tmo_hit_d;

    assign len_d     = {rx_data_i, len_q[7:0]};
    assign len_bad_d = (len_d == 16'd0) || ({1'b0, len_d} > MAX_LEN);
    assign idx_d     = idx_q + 1'b1;
    assign last_d    = (17'(idx_d) == {1'b0, len_q});

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    assign tmo_hit_d = busy_q && !rx_valid_i && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Inter-byte watchdog: restarts on every byte, idles at zero outside a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (rx_valid_i || !busy_q || tmo_hit_d) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end
`else
    assign tmo_hit_d = 1'b0;
`endif

    // Frame parser FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            chk_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            core_ready_q <= 1'b0;
            load_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (tmo_hit_d) begin
                state_q      <= S_ERROR;
                load_error_q <= 1'b1;
                core_ready_q <= 1'b0;
                busy_q       <= 1'b0;
            end else if (rx_valid_i) begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_data_i == SYNC_BYTE) begin
                            state_q      <= S_LEN_LO;
                            busy_q       <= 1'b1;
                            core_ready_q <= 1'b0;
                            load_error_q <= 1'b0;
                        end
                    end
                    S_LEN_LO: begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len_q <= len_d;
                        if (len_bad_d) begin
                            state_q      <= S_ERROR;
                            load_error_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            idx_q   <= '0;
                            chk_q   <= '0;
                            state_q <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= idx_q[ADDR_WIDTH-1:0];
                        mem_data_q <= rx_data_i;
                        idx_q      <= idx_d;
                        chk_q      <= chk_q ^ rx_data_i;
                        if (last_d) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        busy_q <= 1'b0;
                        if (rx_data_i == chk_q) begin
                            state_q      <= S_DONE;
                            core_ready_q <= 1'b1;
                        end else begin
                            state_q      <= S_ERROR;
                            load_error_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_we_o     = mem_we_q;
    assign core_ready_o = core_ready_q;
    assign load_error_o = load_error_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_code_loader.sv
// Bench for uart_code_loader: directed frames from the test plan plus random
// frames checked against a frame-level reference model.
module tb_uart_code_loader;
    localparam int         AW   = 8;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          core_ready;
    logic          load_error;
    logic          busy;
    logic [2:0]    state;

    int total = 0;
    int bad = 0;

    logic [7:0]  tx_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic        exp_ready;
    logic        exp_err;

    // clock
    always #5 clk = ~clk;

    uart_code_loader #(
        .ADDR_WIDTH(AW),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .mem_addr_o(mem_addr),
        .mem_data_o(mem_data),
        .mem_we_o(mem_we),
        .core_ready_o(core_ready),
        .load_error_o(load_error),
        .busy_o(busy),
        .state_o(state)
    );

    // capture every RAM write away from the active edge
    always @(negedge clk) begin
        if (rst_n && mem_we) obs_q.push_back({mem_addr, mem_data});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_tx(input int max_gap);
        while (tx_q.size() > 0) begin
            send(tx_q.pop_front());
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        tx_q.delete();
    endtask

    // Reference model: builds a frame and derives expected writes and flags
    // straight from the frame rules (length range, XOR of payload).
    task automatic make_frame(input int len, input bit corrupt);
        logic [7:0]  b;
        logic [7:0]  x;
        logic [15:0] l;
        bit          len_ok;
        l = 16'(len);
        len_ok = (len >= 1) && (len <= (1 << AW));
        tx_q.push_back(SYNC);
        tx_q.push_back(l[7:0]);
        tx_q.push_back(l[15:8]);
        x = 8'h00;
        if (len_ok) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                tx_q.push_back(b);
                x = x ^ b;
                exp_q.push_back({8'(i), b});
            end
            if (corrupt) x = x ^ 8'($urandom_range(1, 255));
            tx_q.push_back(x);
        end
        exp_ready = len_ok && !corrupt;
        exp_err   = !exp_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", mem_addr); end
        total++; if (mem_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", mem_data); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", core_ready); end
        total++; if (load_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", load_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        clear_sb();
        tx_q  = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        exp_q = '{16'h0011, 16'h0122, 16'h0233};
        send_tx(0);
        total++; if (core_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL good_pre_chk ready=%b busy=%b want ready=0 busy=1", core_ready, busy); end
        send(8'h00);
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL good_ready got=%b want=1", core_ready); end
        total++; if (load_error !== 1'b0) begin bad++; $display("FAIL good_err got=%b want=0", load_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b want=0", busy); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL good_wr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL good_wr[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        // sync byte carried as payload data is not a resync
        clear_sb();
        tx_q  = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'h00};
        exp_q = '{16'h00A5, 16'h01A5};
        send_tx(1);
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL sync_data_ready got=%b want=1", core_ready); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL sync_data_wr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL sync_data_wr[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_checksum();
        clear_sb();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
        send_tx(0);
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL badchk_wr_count got=%0d want=2", obs_q.size()); end
        total++; if (load_error !== 1'b1) begin bad++; $display("FAIL badchk_err got=%b want=1", load_error); end
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL badchk_ready got=%b want=0", core_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL badchk_busy got=%b want=0", busy); end
        send(SYNC);
        total++; if (load_error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL badchk_resync err=%b busy=%b want err=0 busy=1", load_error, busy); end
        tx_q = '{8'h01, 8'h00, 8'h7E, 8'h7E};
        send_tx(0);
        total++; if (core_ready !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL badchk_recover ready=%b err=%b want ready=1 err=0", core_ready, load_error); end
    endtask

    task automatic test_garbage();
        clear_sb();
        tx_q  = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E};
        exp_q = '{16'h007E};
        send_tx(0);
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL garbage_ready got=%b want=1", core_ready); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL garbage_wr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else begin
            total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL garbage_wr got=%h want=%h", obs_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_len_bounds();
        clear_sb();
        tx_q = '{8'hA5, 8'h01, 8'h01};
        send_tx(0);
        repeat (2) tick();
        total++; if (load_error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL len257 err=%b busy=%b want err=1 busy=0", load_error, busy); end
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL len257_wr got=%0d want=0", obs_q.size()); end
        clear_sb();
        tx_q = '{8'hA5, 8'h00, 8'h00};
        send_tx(0);
        repeat (2) tick();
        total++; if (load_error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL len0 err=%b busy=%b want err=1 busy=0", load_error, busy); end
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL len0_wr got=%0d want=0", obs_q.size()); end
        clear_sb();
        make_frame(256, 1'b0);
        send_tx(0);
        total++; if (core_ready !== 1'b1 || load_error !== 1'b0) begin bad++; $display("FAIL len256 ready=%b err=%b want ready=1 err=0", core_ready, load_error); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL len256_wr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL len256_wr[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_sb();
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h10, 8'h20};
        send_tx(0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({mem_addr, mem_data, mem_we, core_ready, load_error, busy} !== 20'h0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", {mem_addr, mem_data, mem_we, core_ready, load_error, busy}); end
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL midrst_partial_wr got=%0d want=2", obs_q.size()); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clear_sb();
        tx_q  = '{8'hA5, 8'h02, 8'h00, 8'hC3, 8'h3C, 8'hFF};
        exp_q = '{16'h00C3, 16'h013C};
        send_tx(0);
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", core_ready); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL midrst_wr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_wr[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int r;
        int len;
        for (int n = 0; n < 25; n++) begin
            clear_sb();
            repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom_range(0, 164)));
            r = $urandom_range(0, 9);
            if (r == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(257, 600);
            else if (r == 1) len = 8'hA5;
            else len = $urandom_range(1, 24);
            make_frame(len, $urandom_range(0, 3) == 0);
            send_tx(2);
            repeat (2) tick();
            total++; if (core_ready !== exp_ready) begin bad++; $display("FAIL rand%0d_ready len=%0d got=%b want=%b", n, len, core_ready, exp_ready); end
            total++; if (load_error !== exp_err) begin bad++; $display("FAIL rand%0d_err len=%0d got=%b want=%b", n, len, load_error, exp_err); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand%0d_busy got=%b want=0", n, busy); end
            total++;
            if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_wr_count got=%0d want=%0d", n, obs_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_wr[%0d] got=%h want=%h", n, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        clear_sb();
        tx_q = '{8'hA5, 8'h04, 8'h00};
        send_tx(0);
`ifdef BOOT_TIMEOUT_EN
        cnt = 0;
        while (load_error !== 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
        end
        total++; if (load_error !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1 after %0d cycles", load_error, cnt); end
        total++; if (cnt < TMO - 10 || cnt > TMO + 10) begin bad++; $display("FAIL timeout_latency got=%0d want=about %0d", cnt, TMO); end
        total++; if (busy !== 1'b0 || core_ready !== 1'b0) begin bad++; $display("FAIL timeout_flags busy=%b ready=%b want 0 0", busy, core_ready); end
`else
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (busy !== 1'b1 || load_error !== 1'b0) cnt++;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL notimeout_stuck bad_cycles got=%0d want=0", cnt); end
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage();
        test_len_bounds();
        test_reset_midframe();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_code_loader.md
Name: uart_code_loader

Overview:
- Framed boot loader between the UART receiver and the code RAM that the processor core fetches from.
- Consumes received bytes, validates a frame (sync, length, payload, XOR checksum) and streams the payload into the code RAM's byte write port.
- Asserts core_ready, which releases the core from hold, only after a complete frame passes its checksum.
- Replaces the free-running byte counter that previously gated the core.

Parameters:
- ADDR_WIDTH, 8, code RAM address width; maximum payload is 2**ADDR_WIDTH bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clk cycles; used only with BOOT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte from the UART.
- rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle.
- mem_addr  output  ADDR_WIDTH  code RAM write address.
- mem_data  output  8  code RAM write data.
- mem_we  output  1  code RAM write strobe, one cycle per byte.
- core_ready  output  1  high while a verified image is resident; core runs.
- load_error  output  1  high after a rejected frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0: mem_addr, mem_data, mem_we, core_ready, load_error, busy.
  - Length, index and checksum registers cleared.
  - Reset mid-frame abandons the frame. RAM keeps any partial contents; core_ready stays 0.
- All other state updates occur on posedge clk. At most one byte is consumed per cycle; rx_valid on consecutive cycles must be accepted with no byte dropped.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CHK.
  - LEN is 16-bit little-endian.
  - CHK is the XOR of all payload bytes.
- States and transitions, each taken on rx_valid:
  - IDLE: SYNC_BYTE -> LEN_LO. Any other byte is ignored.
  - LEN_LO: latch the low length byte -> LEN_HI.
  - LEN_HI: latch the high length byte.
    - If LEN==0 or LEN>2**ADDR_WIDTH -> ERROR.
    - Otherwise clear index and checksum -> PAYLOAD.
  - PAYLOAD: on each byte, in the next cycle drive mem_we=1, mem_addr=index, mem_data=byte.
    - Then index+=1 and checksum^=byte.
    - After byte number LEN -> CHECK.
  - CHECK: if CHK==checksum -> DONE, otherwise -> ERROR.
  - DONE: core_ready=1. SYNC_BYTE -> LEN_LO and core_ready drops. Other bytes are ignored.
  - ERROR: load_error=1, core_ready=0. SYNC_BYTE -> LEN_LO and load_error clears. Other bytes are ignored.
- Output timing:
  - core_ready and load_error are registered. They change in the cycle after the rx_valid that causes the transition.
  - mem_we is a registered single-cycle pulse, 1 cycle after the payload rx_valid.
  - Writes are never merged or skipped.
- busy = state in {LEN_LO, LEN_HI, PAYLOAD, CHECK}, registered with the state.
- Index width is ADDR_WIDTH+1 so that LEN=2**ADDR_WIDTH terminates correctly. mem_addr takes the low ADDR_WIDTH bits.
- A SYNC_BYTE value inside length, payload or CHK is treated as data, not resync.
- Payload is written before verification. After ERROR, RAM content is undefined and the core stays held.

Optional Feature:
- Macro: BOOT_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on every rx_valid and counts while busy=1.
  - When it reaches TIMEOUT_CYCLES, the block goes to ERROR, load_error=1 next cycle.
  - The counter is held at 0 when busy=0.
- Without the macro:
  - No counter exists.
  - An incomplete frame waits indefinitely with busy=1.

Test Plan:
- Good frame A5 03 00 11 22 33 00 -> mem_we pulses at addr 0/1/2 with data 11/22/33; core_ready=1 in the cycle after CHK; load_error=0; busy=0.
- Bad checksum A5 02 00 AA 55 00 (expected FF) -> two writes occur; load_error=1; core_ready=0. Then A5 01 00 7E 7E -> load_error clears at sync; core_ready=1.
- Leading garbage 00 FF 13 then A5 01 00 7E 7E sent with rx_valid every cycle -> prefix ignored; single write addr0=7E; core_ready=1.
- Length bounds with ADDR_WIDTH=8:
  - A5 01 01 -> ERROR after LEN_HI, no mem_we.
  - A5 00 01 plus 256 bytes plus XOR -> addr 00..FF written; core_ready=1.
  - A5 00 00 -> ERROR.
- Reset mid-frame: drop rst_n after 2 of 4 payload bytes -> all outputs 0 immediately (asynchronously). A following full frame writes from addr 0 and sets core_ready.
- Timeout: BOOT_TIMEOUT_EN, TIMEOUT_CYCLES=100, send A5 04 00 then stop.
  - Macro defined -> load_error=1 about 100 cycles after the last byte; busy=0.
  - Macro undefined -> busy stays 1 for 10000 cycles.
